// File: rtl/multi_block_core.sv
// Multi-block tile overlay: up to NUM_BLK square tiles, chroma-keyed over a pixel stream.
// Block registers are double-buffered and swap in at frame start; a readable frame counter is included.
module multi_block_core #(
    parameter int CD = 12,
    parameter int NUM_BLK = 4,
    parameter int BLK_BITS = 4,
    parameter int PAT_BITS = 2,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);
    localparam int AW = PAT_BITS + 2 * BLK_BITS;
    localparam logic [11:0] BLK_EDGE = 12'(1 << BLK_BITS);

    logic                        frame_start;
    logic                        pat_we;
    logic                        blk_we;
    logic                        glb_we;
    logic [2:0]                  blk_idx;
    logic                        bypass_reg;
    logic [15:0]                 frame_cnt_reg;
    logic [CD-1:0]               si_reg;
    logic [CD-1:0]               so_next;
    logic [NUM_BLK-1:0]          hit_vec;
    logic [NUM_BLK-1:0][CD-1:0]  pix_vec;
    logic                        unused_bits;

    assign frame_start = (x == 11'd0) && (y == 11'd0);
    assign pat_we      = cs && write && !addr[13];
    assign blk_we      = cs && write && (addr[13:12] == 2'b10);
    assign glb_we      = cs && write && (addr[13:12] == 2'b11);
    assign blk_idx     = addr[4:2];
    assign unused_bits = ^{addr, wr_data};

    generate
        for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
            logic [10:0]         x0_shadow_reg, y0_shadow_reg, x0_reg, y0_reg;
            logic                en_shadow_reg, en_reg;
            logic [PAT_BITS-1:0] pat_shadow_reg, pat_reg;
            logic [CD-1:0]       ram [0:(1 << AW) - 1];
            logic [CD-1:0]       ram_q_reg;
            logic                hit_reg;
            logic [11:0]         dx, dy;
            logic                hit;
            logic [AW-1:0]       rd_addr;
            logic                unused_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    x0_shadow_reg  <= '0;
                    y0_shadow_reg  <= '0;
                    en_shadow_reg  <= 1'b0;
                    pat_shadow_reg <= '0;
                    x0_reg         <= '0;
                    y0_reg         <= '0;
                    en_reg         <= 1'b0;
                    pat_reg        <= '0;
                end else begin
                    if (blk_we && (blk_idx == 3'(gi))) begin
                        case (addr[1:0])
                            2'b00:   x0_shadow_reg <= wr_data[10:0];
                            2'b01:   y0_shadow_reg <= wr_data[10:0];
                            2'b10: begin
                                en_shadow_reg  <= wr_data[0];
                                pat_shadow_reg <= wr_data[PAT_BITS:1];
                            end
                            default: ;
                        endcase
                    end
                    // Active copies take the pre-write shadow when a write lands on frame start.
                    if (frame_start) begin
                        x0_reg  <= x0_shadow_reg;
                        y0_reg  <= y0_shadow_reg;
                        en_reg  <= en_shadow_reg;
                        pat_reg <= pat_shadow_reg;
                    end
                end
            end

            assign dx      = {1'b0, x} - {1'b0, x0_reg};
            assign dy      = {1'b0, y} - {1'b0, y0_reg};
            assign hit     = en_reg
                           && ({1'b0, x} >= {1'b0, x0_reg}) && ({1'b0, x} < ({1'b0, x0_reg} + BLK_EDGE))
                           && ({1'b0, y} >= {1'b0, y0_reg}) && ({1'b0, y} < ({1'b0, y0_reg} + BLK_EDGE));
            assign rd_addr = {pat_reg, dy[BLK_BITS-1:0], dx[BLK_BITS-1:0]};
            assign unused_d = ^{dx[11:BLK_BITS], dy[11:BLK_BITS]};

            // One replica per block gives each tile its own read port.
            always_ff @(posedge clk) begin
                if (pat_we) begin
                    ram[addr[AW-1:0]] <= wr_data[CD-1:0];
                end
                ram_q_reg <= ram[rd_addr];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    hit_reg <= 1'b0;
                end else begin
                    hit_reg <= hit;
                end
            end

            assign hit_vec[gi] = hit_reg;
            assign pix_vec[gi] = ram_q_reg;
        end
    endgenerate

    // Walk from the highest index down so the lowest-index opaque hit wins.
    always_comb begin
        so_next = si_reg;
        for (int b = NUM_BLK - 1; b >= 0; b--) begin
            if (hit_vec[b] && (pix_vec[b] != KEY_COLOR)) begin
                so_next = pix_vec[b];
            end
        end
        if (bypass_reg) begin
            so_next = si_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            si_reg <= '0;
            so_rgb <= '0;
        end else begin
            si_reg <= si_rgb;
            so_rgb <= so_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bypass_reg    <= 1'b0;
            frame_cnt_reg <= '0;
            rd_data       <= '0;
        end else begin
            if (glb_we && (addr[1:0] == 2'b00)) begin
                bypass_reg <= wr_data[0];
            end
            if (glb_we && (addr[1:0] == 2'b01)) begin
                frame_cnt_reg <= '0;
            end else if (frame_start) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (cs && read) begin
                rd_data <= ((addr[13:12] == 2'b11) && (addr[1:0] == 2'b01)) ? {16'b0, frame_cnt_reg} : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_multi_block_core.sv
// Directed bench for multi_block_core: passthrough, tiles, overlap priority,
// shadow timing, frame counter, bypass and mid-frame reset.
module tb_multi_block_core;
    localparam int CD = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [10:0]   x = 11'd5;
    logic [10:0]   y = 11'd5;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [13:0]   addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic [CD-1:0] si_rgb = 12'h123;
    logic [CD-1:0] so_rgb;

    int n_checks = 0;
    int n_fail = 0;

    multi_block_core #(
        .CD(CD), .NUM_BLK(4), .BLK_BITS(4), .PAT_BITS(2), .KEY_COLOR(12'h000)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int xv, input int yv, input int sv);
        x = 11'(xv); y = 11'(yv); si_rgb = 12'(sv);
        @(posedge clk); #1;
    endtask

    // Drive one pixel then an idle pixel; so_rgb then holds that pixel's result.
    task automatic probe(input int xv, input int yv, input int sv);
        step(xv, yv, sv);
        step(2047, 2000, 0);
    endtask

    task automatic bus_write(input int a, input int d);
        x = 11'd2047; y = 11'd2000;
        cs = 1'b1; write = 1'b1; addr = 14'(a); wr_data = 32'(d);
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input int a);
        x = 11'd2047; y = 11'd2000;
        cs = 1'b1; read = 1'b1; addr = 14'(a);
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic load_pattern(input int pat, input int val);
        for (int i = 0; i < 256; i++) bus_write(pat * 256 + i, val);
    endtask

    task automatic test_reset;
        logic [11:0] prev;
        logic [11:0] sv;
        x = 11'd5; y = 11'd5; si_rgb = 12'h123; reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL reset_so: so_rgb=%h expected 000", so_rgb); end
        else $display("reset_so ok so_rgb=%h", so_rgb);
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd: rd_data=%h expected 0", rd_data); end
        else $display("reset_rd ok rd_data=%h", rd_data);
        reset = 1'b0;
        step(5, 6, 12'h123);
        n_checks++; if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL post_reset_1: so_rgb=%h expected 000", so_rgb); end
        else $display("post_reset_1 ok so_rgb=%h", so_rgb);
        step(6, 6, 12'h123);
        n_checks++; if (so_rgb !== 12'h123) begin n_fail++; $display("FAIL post_reset_2: so_rgb=%h expected 123", so_rgb); end
        else $display("post_reset_2 ok so_rgb=%h", so_rgb);
        for (int i = 0; i < 10; i++) begin
            step(i * 37, i * 11, 12'h123);
            n_checks++; if (so_rgb !== 12'h123) begin n_fail++; $display("FAIL pass_const: i=%0d so_rgb=%h expected 123", i, so_rgb); end
            else $display("pass_const ok i=%0d so_rgb=%h", i, so_rgb);
        end
        prev = 12'h000;
        for (int i = 0; i < 8; i++) begin
            sv = 12'(12'h100 + i * 17);
            step(300 + i, 400, int'(sv));
            if (i > 0) begin
                n_checks++; if (so_rgb !== prev) begin n_fail++; $display("FAIL pass_latency: i=%0d so_rgb=%h expected %h", i, so_rgb, prev); end
                else $display("pass_latency ok i=%0d so_rgb=%h", i, so_rgb);
            end
            prev = sv;
        end
    endtask

    task automatic test_single_block;
        int yl[5] = '{49, 50, 58, 65, 66};
        logic [11:0] exp;
        load_pattern(1, 12'hF00);
        bus_write(14'h2000, 100);
        bus_write(14'h2001, 50);
        bus_write(14'h2002, 3);
        probe(100, 50, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h0AA) begin n_fail++; $display("FAIL shadow_not_active: so_rgb=%h expected 0aa", so_rgb); end
        else $display("shadow_not_active ok so_rgb=%h", so_rgb);
        step(0, 0, 0);
        foreach (yl[k]) begin
            for (int xs = 98; xs < 118; xs++) begin
                probe(xs, yl[k], 12'h0AA);
                exp = (xs >= 100 && xs <= 115 && yl[k] >= 50 && yl[k] <= 65) ? 12'hF00 : 12'h0AA;
                n_checks++; if (so_rgb !== exp) begin n_fail++; $display("FAIL block0: x=%0d y=%0d so_rgb=%h expected %h", xs, yl[k], so_rgb, exp); end
            end
            $display("block0 row y=%0d scanned", yl[k]);
        end
    endtask

    task automatic test_screen_edge;
        int xl[5] = '{2039, 2040, 2047, 0, 7};
        logic [11:0] el[5] = '{12'h055, 12'hF00, 12'hF00, 12'h055, 12'h055};
        bus_write(14'h2004, 2040);
        bus_write(14'h2005, 10);
        bus_write(14'h2006, 3);
        step(0, 0, 0);
        foreach (xl[k]) begin
            probe(xl[k], 12, 12'h055);
            n_checks++; if (so_rgb !== el[k]) begin n_fail++; $display("FAIL edge: x=%0d so_rgb=%h expected %h", xl[k], so_rgb, el[k]); end
            else $display("edge ok x=%0d so_rgb=%h", xl[k], so_rgb);
        end
    endtask

    task automatic test_overlap;
        int px[11] = '{210, 211, 208, 207, 216, 223, 224, 215, 216, 230, 405};
        int py[11] = '{306, 306, 304, 306, 306, 319, 319, 315, 315, 306, 405};
        logic [11:0] pe[11] = '{12'h0F0, 12'h00F, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0,
                                12'h0AA, 12'h00F, 12'h0F0, 12'h0AA, 12'h0AA};
        load_pattern(2, 12'h0F0);
        load_pattern(3, 12'h00F);
        bus_write(3 * 256 + 6 * 16 + 10, 12'h000);
        bus_write(14'h2000, 200); bus_write(14'h2001, 300); bus_write(14'h2002, 7);
        bus_write(14'h2008, 208); bus_write(14'h2009, 304); bus_write(14'h200A, 5);
        bus_write(14'h2014, 400); bus_write(14'h2015, 400); bus_write(14'h2016, 5);
        step(0, 0, 0);
        foreach (px[k]) begin
            probe(px[k], py[k], 12'h0AA);
            n_checks++; if (so_rgb !== pe[k]) begin n_fail++; $display("FAIL overlap: x=%0d y=%0d so_rgb=%h expected %h", px[k], py[k], so_rgb, pe[k]); end
            else $display("overlap ok x=%0d y=%0d so_rgb=%h", px[k], py[k], so_rgb);
        end
    endtask

    task automatic test_shadow;
        bus_write(14'h2000, 600);
        probe(205, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h00F) begin n_fail++; $display("FAIL mid_old: so_rgb=%h expected 00f", so_rgb); end
        else $display("mid_old ok so_rgb=%h", so_rgb);
        probe(605, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h0AA) begin n_fail++; $display("FAIL mid_new: so_rgb=%h expected 0aa", so_rgb); end
        else $display("mid_new ok so_rgb=%h", so_rgb);
        step(0, 0, 0);
        probe(605, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h00F) begin n_fail++; $display("FAIL next_new: so_rgb=%h expected 00f", so_rgb); end
        else $display("next_new ok so_rgb=%h", so_rgb);
        probe(205, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h0AA) begin n_fail++; $display("FAIL next_old: so_rgb=%h expected 0aa", so_rgb); end
        else $display("next_old ok so_rgb=%h", so_rgb);
        // Write lands on the frame-start cycle itself.
        x = 11'd0; y = 11'd0; si_rgb = 12'h000;
        cs = 1'b1; write = 1'b1; addr = 14'h2000; wr_data = 32'd900;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
        probe(605, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h00F) begin n_fail++; $display("FAIL coinc_old: so_rgb=%h expected 00f", so_rgb); end
        else $display("coinc_old ok so_rgb=%h", so_rgb);
        probe(905, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h0AA) begin n_fail++; $display("FAIL coinc_new_early: so_rgb=%h expected 0aa", so_rgb); end
        else $display("coinc_new_early ok so_rgb=%h", so_rgb);
        step(0, 0, 0);
        probe(905, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h00F) begin n_fail++; $display("FAIL coinc_new: so_rgb=%h expected 00f", so_rgb); end
        else $display("coinc_new ok so_rgb=%h", so_rgb);
        probe(605, 305, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h0AA) begin n_fail++; $display("FAIL coinc_old_gone: so_rgb=%h expected 0aa", so_rgb); end
        else $display("coinc_old_gone ok so_rgb=%h", so_rgb);
    endtask

    task automatic test_frame_cnt;
        bus_write(14'h3001, 0);
        repeat (3) step(0, 0, 0);
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'd3) begin n_fail++; $display("FAIL cnt3: rd_data=%h expected 3", rd_data); end
        else $display("cnt3 ok rd_data=%h", rd_data);
        step(0, 0, 0);
        n_checks++; if (rd_data !== 32'd3) begin n_fail++; $display("FAIL rd_hold: rd_data=%h expected 3", rd_data); end
        else $display("rd_hold ok rd_data=%h", rd_data);
        bus_read(14'h3000);
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rd_other: rd_data=%h expected 0", rd_data); end
        else $display("rd_other ok rd_data=%h", rd_data);
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'd4) begin n_fail++; $display("FAIL cnt4: rd_data=%h expected 4", rd_data); end
        else $display("cnt4 ok rd_data=%h", rd_data);
        bus_write(14'h3001, 0);
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL clear: rd_data=%h expected 0", rd_data); end
        else $display("clear ok rd_data=%h", rd_data);
        repeat (2) step(0, 0, 0);
        x = 11'd0; y = 11'd0;
        cs = 1'b1; write = 1'b1; addr = 14'h3001; wr_data = 32'd0;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL clear_wins: rd_data=%h expected 0", rd_data); end
        else $display("clear_wins ok rd_data=%h", rd_data);
        x = 11'd0; y = 11'd0;
        repeat (65535) @(posedge clk);
        #1;
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'h0000FFFF) begin n_fail++; $display("FAIL cnt_max: rd_data=%h expected 0000ffff", rd_data); end
        else $display("cnt_max ok rd_data=%h", rd_data);
        step(0, 0, 0);
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap: rd_data=%h expected 0", rd_data); end
        else $display("cnt_wrap ok rd_data=%h", rd_data);
    endtask

    task automatic test_bypass;
        logic [11:0] prev;
        bus_write(14'h3000, 1);
        prev = 12'h000;
        for (int i = 0; i < 8; i++) begin
            step(208 + i, 310, 12'h200 + i);
            if (i > 0) begin
                n_checks++; if (so_rgb !== prev) begin n_fail++; $display("FAIL bypass: i=%0d so_rgb=%h expected %h", i, so_rgb, prev); end
                else $display("bypass ok i=%0d so_rgb=%h", i, so_rgb);
            end
            prev = 12'(12'h200 + i);
        end
        bus_write(14'h3000, 0);
        probe(210, 310, 12'h0AA);
        n_checks++; if (so_rgb !== 12'h0F0) begin n_fail++; $display("FAIL bypass_off: so_rgb=%h expected 0f0", so_rgb); end
        else $display("bypass_off ok so_rgb=%h", so_rgb);
    endtask

    task automatic test_reset_mid;
        x = 11'd212; y = 11'd310; si_rgb = 12'h456; reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL mid_reset_so: so_rgb=%h expected 000", so_rgb); end
        else $display("mid_reset_so ok so_rgb=%h", so_rgb);
        reset = 1'b0;
        step(213, 310, 12'h456);
        n_checks++; if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL mid_post_1: so_rgb=%h expected 000", so_rgb); end
        else $display("mid_post_1 ok so_rgb=%h", so_rgb);
        step(214, 310, 12'h456);
        n_checks++; if (so_rgb !== 12'h456) begin n_fail++; $display("FAIL mid_post_2: so_rgb=%h expected 456", so_rgb); end
        else $display("mid_post_2 ok so_rgb=%h", so_rgb);
        step(215, 311, 12'h457);
        n_checks++; if (so_rgb !== 12'h456) begin n_fail++; $display("FAIL mid_post_3: so_rgb=%h expected 456", so_rgb); end
        else $display("mid_post_3 ok so_rgb=%h", so_rgb);
        bus_read(14'h3001);
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: rd_data=%h expected 0", rd_data); end
        else $display("mid_cnt ok rd_data=%h", rd_data);
        step(0, 0, 0);
        probe(212, 310, 12'h456);
        n_checks++; if (so_rgb !== 12'h456) begin n_fail++; $display("FAIL mid_disabled: so_rgb=%h expected 456", so_rgb); end
        else $display("mid_disabled ok so_rgb=%h", so_rgb);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_screen_edge();
        test_overlap();
        test_shadow();
        test_frame_cnt();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
